// File: rtl/jt12_eg_gen.sv
// jt12_eg_gen: FM envelope generator (ADSR) with attenuation output.
// eg_pure is attenuation: 0 is loudest and 3FFh is silent.
// All state advances only on clk_en ticks.
// Optional SSG-EG behaviour is compiled in when JT12_EG_SSG_EN is defined.
// Without the macro, the ssg_* inputs are ignored and ssg_inv stays 0.
module jt12_eg_gen #(
   parameter int SLW = 4
) (
   input  logic           rst,
   input  logic           clk,
   input  logic           clk_en,
   input  logic           keyon,
   input  logic [4:0]     ar,
   input  logic [4:0]     d1r,
   input  logic [4:0]     d2r,
   input  logic [3:0]     rr,
   input  logic [SLW-1:0] sl,
   input  logic           ssg_en,
   input  logic           ssg_alt,
   input  logic           ssg_hold,
   output logic [9:0]     eg_pure,
   output logic           ssg_inv,
   output logic [2:0]     eg_state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } eg_state_t;

   eg_state_t   state;
   logic [11:0] eg_cnt;
   logic        keyon_last;
   logic        key_rise;
   logic        key_fall;
   logic [5:0]  r6;
   logic [3:0]  rsel;
   logic [3:0]  shift;
   logic [3:0]  inc;
   logic [10:0] cnt_mask;
   logic        step_en;
   logic [9:0]  sl_thr;
   logic [5:0]  inc_eff;
   logic [10:0] add_sum;
   logic [9:0]  add_next;
   logic [10:0] att_sub;
   logic [9:0]  att_next;
   logic        ssg_boost;
   logic        ssg_freeze;
   logic        ssg_restart;
   logic        ssg_inv_load;

   // The state register doubles as the debug/status output.
   assign eg_state = state;

   // Key edges are judged against the level captured on the previous tick.
   assign key_rise = keyon & ~keyon_last;
   assign key_fall = ~keyon & keyon_last;

   // Select the 6-bit effective rate for the current phase. IDLE never moves.
   always_comb begin
      r6 = 6'd0;
      case (state)
         ST_ATTACK:  r6 = {ar, 1'b0};
         ST_DECAY:   r6 = {d1r, 1'b0};
         ST_SUSTAIN: r6 = {d2r, 1'b0};
         ST_RELEASE: r6 = {rr, 2'b10};
         default:    r6 = 6'd0;
      endcase
   end

   assign rsel = r6[5:2];

   // Low rates step only when the low bits of the tick counter are zero.
   // High rates step every tick and take a larger increment instead.
   always_comb begin
      shift = (rsel < 4'd11) ? (4'd11 - rsel) : 4'd0;
      case (rsel)
         4'd12:        inc = 4'd2;
         4'd13:        inc = 4'd4;
         4'd14, 4'd15: inc = 4'd8;
         default:      inc = 4'd1;
      endcase
   end

   assign cnt_mask = ~(11'h7FF << shift);
   assign step_en  = (r6 != 6'd0) && ((eg_cnt & {1'b0, cnt_mask}) == 12'd0);

   // The decay-to-sustain threshold is sl<<5. The all-ones level is
   // special-cased to 3E0h so that the top sustain level reaches near silence.
   always_comb begin
      sl_thr = 10'(sl) << 5;
      if (&sl) begin
         sl_thr = 10'h3E0;
      end
   end

   // Attack moves exponentially toward 0, so the step is scaled by the level.
   always_comb begin
      att_sub  = ({5'd0, eg_pure[9:4]} + 11'd1) * {7'd0, inc};
      att_next = (att_sub >= {1'b0, eg_pure}) ? 10'd0 : (eg_pure - att_sub[9:0]);
   end

   // Decay, sustain and release move linearly toward 3FFh and saturate there.
   always_comb begin
      inc_eff  = ssg_boost ? {inc, 2'b00} : {2'b00, inc};
      add_sum  = {1'b0, eg_pure} + {5'd0, inc_eff};
      add_next = add_sum[10] ? 10'h3FF : add_sum[9:0];
   end

`ifdef JT12_EG_SSG_EN
   // SSG-EG uses a quadrupled decay rate. Once the level crosses 200h, it
   // either loops back into attack or freezes at the current level.
   always_comb begin
      ssg_boost    = 1'b0;
      ssg_freeze   = 1'b0;
      ssg_restart  = 1'b0;
      ssg_inv_load = ssg_inv;
      if (ssg_en && (state == ST_DECAY || state == ST_SUSTAIN)) begin
         ssg_boost = 1'b1;
         if (eg_pure >= 10'h200) begin
            if (ssg_hold) begin
               ssg_freeze   = 1'b1;
               ssg_inv_load = ssg_alt;
            end else begin
               ssg_restart  = 1'b1;
               ssg_inv_load = ssg_inv ^ ssg_alt;
            end
         end
      end
   end
`else
   logic unused_ssg;
   assign unused_ssg   = ssg_en ^ ssg_alt ^ ssg_hold;
   assign ssg_boost    = 1'b0;
   assign ssg_freeze   = 1'b0;
   assign ssg_restart  = 1'b0;
   assign ssg_inv_load = 1'b0;
`endif

   // Envelope FSM. A key edge only changes state on its tick. Any other
   // tick applies one rate step. Phase exits are judged on the stepped value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         eg_pure    <= 10'h3FF;
         eg_cnt     <= 12'd0;
         keyon_last <= 1'b0;
         ssg_inv    <= 1'b0;
      end else if (clk_en) begin
         eg_cnt     <= eg_cnt + 12'd1;
         keyon_last <= keyon;
         if (key_rise) begin
            ssg_inv <= 1'b0;
            if (ar == 5'd31) begin
               eg_pure <= 10'd0;
               state   <= ST_DECAY;
            end else begin
               state   <= ST_ATTACK;
            end
         end else if (key_fall) begin
            ssg_inv <= 1'b0;
            state   <= ST_RELEASE;
         end else if (step_en) begin
            case (state)
               ST_ATTACK: begin
                  eg_pure <= att_next;
                  if (att_next == 10'd0) begin
                     state <= ST_DECAY;
                  end
               end
               ST_DECAY, ST_SUSTAIN: begin
                  if (ssg_freeze || ssg_restart) begin
                     ssg_inv <= ssg_inv_load;
                  end
                  if (ssg_restart) begin
                     state <= ST_ATTACK;
                  end else if (!ssg_freeze) begin
                     eg_pure <= add_next;
                     if (state == ST_DECAY && add_next >= sl_thr) begin
                        state <= ST_SUSTAIN;
                     end
                  end
               end
               ST_RELEASE: begin
                  eg_pure <= add_next;
                  if (add_next == 10'h3FF) begin
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jt12_eg_gen.sv
// tb_jt12_eg_gen: self-checking bench for jt12_eg_gen.
// Expected {ssg_inv, eg_state, eg_pure} triples are queued before each run of
// ticks and popped one per tick. Outputs are sampled 1ns after the clock edge.
// The SSG scenario follows JT12_EG_SSG_EN in the same way as the design.
module tb_jt12_eg_gen;

   logic        rst;
   logic        clk;
   logic        clk_en;
   logic        keyon;
   logic [4:0]  ar;
   logic [4:0]  d1r;
   logic [4:0]  d2r;
   logic [3:0]  rr;
   logic [3:0]  sl;
   logic        ssg_en;
   logic        ssg_alt;
   logic        ssg_hold;
   logic [9:0]  eg_pure;
   logic        ssg_inv;
   logic [2:0]  eg_state;

   logic [13:0] exp_q[$];
   logic [11:0] tb_cnt;
   int          checks = 0;
   int          errors = 0;

   jt12_eg_gen #(.SLW(4)) dut (
      .rst      (rst),
      .clk      (clk),
      .clk_en   (clk_en),
      .keyon    (keyon),
      .ar       (ar),
      .d1r      (d1r),
      .d2r      (d2r),
      .rr       (rr),
      .sl       (sl),
      .ssg_en   (ssg_en),
      .ssg_alt  (ssg_alt),
      .ssg_hold (ssg_hold),
      .eg_pure  (eg_pure),
      .ssg_inv  (ssg_inv),
      .eg_state (eg_state)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One EG tick. Inputs are set before the call. Outputs are read on return.
   task automatic tick();
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      clk_en = 1'b0;
      tb_cnt = tb_cnt + 12'd1;
   endtask

   // Asynchronous reset pulse placed between clock edges. keyon is left alone.
   task automatic apply_reset();
      @(posedge clk);
      #2;
      rst      = 1'b1;
      clk_en   = 1'b0;
      ar       = 5'd0;
      d1r      = 5'd0;
      d2r      = 5'd0;
      rr       = 4'd0;
      sl       = 4'd0;
      ssg_en   = 1'b0;
      ssg_alt  = 1'b0;
      ssg_hold = 1'b0;
      #2;
      rst    = 1'b0;
      tb_cnt = 12'd0;
   endtask

   task automatic test_reset();
      logic [13:0] e;
      int n;
      keyon = 1'b0;
      apply_reset();
      checks++;
      if (eg_pure !== 10'h3FF) begin
         errors++;
         $display("FAIL reset_pure: got %03h expected 3ff", eg_pure);
      end
      checks++;
      if (eg_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d expected 0", eg_state);
      end
      checks++;
      if (dut.eg_cnt !== 12'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %03h expected 000", dut.eg_cnt);
      end
      checks++;
      if (ssg_inv !== 1'b0) begin
         errors++;
         $display("FAIL reset_inv: got %0b expected 0", ssg_inv);
      end
      // Full attack curve at ar=28 (inc 8, one step per tick) from 3FFh.
      ar    = 5'd28;
      keyon = 1'b1;
      exp_q.push_back({1'b0, 3'd1, 10'h3FF});
      exp_q.push_back({1'b0, 3'd1, 10'h1FF});
      exp_q.push_back({1'b0, 3'd1, 10'h0FF});
      exp_q.push_back({1'b0, 3'd1, 10'h07F});
      exp_q.push_back({1'b0, 3'd1, 10'h03F});
      exp_q.push_back({1'b0, 3'd1, 10'h01F});
      exp_q.push_back({1'b0, 3'd1, 10'h00F});
      exp_q.push_back({1'b0, 3'd1, 10'h007});
      exp_q.push_back({1'b0, 3'd2, 10'h000});
      n = 0;
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({ssg_inv, eg_state, eg_pure} !== e) begin
            errors++;
            $display("FAIL attack_curve %0d: got inv=%0b st=%0d pure=%03h expected inv=%0b st=%0d pure=%03h",
                     n, ssg_inv, eg_state, eg_pure, e[13], e[12:10], e[9:0]);
         end
         n++;
      end
      // Reset in the middle of an attack.
      keyon = 1'b0;
      apply_reset();
      ar    = 5'd28;
      keyon = 1'b1;
      tick();
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({eg_state, eg_pure} !== {3'd0, 10'h3FF}) begin
         errors++;
         $display("FAIL mid_attack_rst: got st=%0d pure=%03h expected st=0 pure=3ff", eg_state, eg_pure);
      end
      checks++;
      if (dut.eg_cnt !== 12'd0) begin
         errors++;
         $display("FAIL mid_attack_rst_cnt: got %03h expected 000", dut.eg_cnt);
      end
      @(posedge clk);
      #1;
      rst    = 1'b0;
      tb_cnt = 12'd0;
      // keyon is still high, so the first tick after reset counts as a rising edge.
      exp_q.push_back({1'b0, 3'd1, 10'h3FF});
      exp_q.push_back({1'b0, 3'd1, 10'h1FF});
      n = 0;
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({ssg_inv, eg_state, eg_pure} !== e) begin
            errors++;
            $display("FAIL post_rst_attack %0d: got inv=%0b st=%0d pure=%03h expected inv=%0b st=%0d pure=%03h",
                     n, ssg_inv, eg_state, eg_pure, e[13], e[12:10], e[9:0]);
         end
         n++;
      end
   endtask

   task automatic test_instant_attack();
      keyon = 1'b1;
      apply_reset();
      ar = 5'd31;
      exp_q.push_back({1'b0, 3'd2, 10'h000});
      tick();
      checks++;
      if ({ssg_inv, eg_state, eg_pure} !== exp_q[0]) begin
         errors++;
         $display("FAIL instant_attack: got st=%0d pure=%03h expected st=2 pure=000", eg_state, eg_pure);
      end
      // With clk_en low, nothing moves, including the tick counter.
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({ssg_inv, eg_state, eg_pure} !== exp_q.pop_front()) begin
         errors++;
         $display("FAIL hold_outputs: got st=%0d pure=%03h expected st=2 pure=000", eg_state, eg_pure);
      end
      checks++;
      if (dut.eg_cnt !== tb_cnt) begin
         errors++;
         $display("FAIL hold_cnt: got %03h expected %03h", dut.eg_cnt, tb_cnt);
      end
   endtask

   task automatic test_decay_release();
      logic [13:0] e;
      logic [10:0] p;
      int n;
      // Decay from 000h at inc 8 toward sl=2 (040h), then hold at d2r=0.
      d1r = 5'd31;
      sl  = 4'd2;
      for (int k = 1; k <= 8; k++) begin
         p = 11'(k * 8);
         exp_q.push_back({1'b0, (p >= 11'h040) ? 3'd3 : 3'd2, p[9:0]});
      end
      exp_q.push_back({1'b0, 3'd3, 10'h040});
      n = 0;
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({ssg_inv, eg_state, eg_pure} !== e) begin
            errors++;
            $display("FAIL decay %0d: got inv=%0b st=%0d pure=%03h expected inv=%0b st=%0d pure=%03h",
                     n, ssg_inv, eg_state, eg_pure, e[13], e[12:10], e[9:0]);
         end
         n++;
      end
      // Sustain climbs to 100h. Key-off there, then release at inc 8 to 3FFh.
      d2r = 5'd31;
      for (int k = 1; k <= 24; k++) begin
         p = 11'h040 + 11'(k * 8);
         exp_q.push_back({1'b0, 3'd3, p[9:0]});
      end
      exp_q.push_back({1'b0, 3'd4, 10'h100});
      for (int k = 1; k <= 96; k++) begin
         p = 11'h100 + 11'(k * 8);
         if (p > 11'h3FF) p = 11'h3FF;
         exp_q.push_back({1'b0, (k == 96) ? 3'd0 : 3'd4, p[9:0]});
      end
      exp_q.push_back({1'b0, 3'd0, 10'h3FF});
      exp_q.push_back({1'b0, 3'd0, 10'h3FF});
      n = 0;
      while (exp_q.size() > 0) begin
         if (n == 24) begin
            d2r   = 5'd0;
            rr    = 4'd15;
            keyon = 1'b0;
         end
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({ssg_inv, eg_state, eg_pure} !== e) begin
            errors++;
            $display("FAIL sustain_release %0d: got inv=%0b st=%0d pure=%03h expected inv=%0b st=%0d pure=%03h",
                     n, ssg_inv, eg_state, eg_pure, e[13], e[12:10], e[9:0]);
         end
         n++;
      end
   endtask

   task automatic test_back_to_back();
      logic [13:0] e;
      int n;
      keyon = 1'b0;
      apply_reset();
      ar    = 5'd31;
      keyon = 1'b1;
      exp_q.push_back({1'b0, 3'd2, 10'h000});
      for (int k = 1; k <= 10; k++) exp_q.push_back({1'b0, 3'd2, 10'(k * 8)});
      exp_q.push_back({1'b0, 3'd4, 10'h050});
      exp_q.push_back({1'b0, 3'd4, 10'h058});
      exp_q.push_back({1'b0, 3'd4, 10'h060});
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 3'd1, 10'h060});
      exp_q.push_back({1'b0, 3'd4, 10'h060});
      exp_q.push_back({1'b0, 3'd4, 10'h068});
      exp_q.push_back({1'b0, 3'd2, 10'h000});
      n = 0;
      while (exp_q.size() > 0) begin
         case (n)
            1:  begin d1r = 5'd31; sl = 4'hF; end
            11: begin d1r = 5'd0; rr = 4'd15; keyon = 1'b0; end
            14: begin ar = 5'd0; keyon = 1'b1; end
            18: keyon = 1'b0;
            20: begin ar = 5'd31; keyon = 1'b1; end
            default: ;
         endcase
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({ssg_inv, eg_state, eg_pure} !== e) begin
            errors++;
            $display("FAIL back_to_back %0d: got inv=%0b st=%0d pure=%03h expected inv=%0b st=%0d pure=%03h",
                     n, ssg_inv, eg_state, eg_pure, e[13], e[12:10], e[9:0]);
         end
         n++;
      end
   endtask

   task automatic test_slow_rate();
      logic [13:0] e;
      logic [9:0] p;
      int n;
      keyon = 1'b0;
      apply_reset();
      ar    = 5'd31;
      keyon = 1'b1;
      exp_q.push_back({1'b0, 3'd2, 10'h000});
      exp_q.push_back({1'b0, 3'd3, 10'h008});
      n = 0;
      while (exp_q.size() > 0) begin
         if (n == 1) begin d1r = 5'd31; sl = 4'd0; end
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({ssg_inv, eg_state, eg_pure} !== e) begin
            errors++;
            $display("FAIL slow_setup %0d: got inv=%0b st=%0d pure=%03h expected inv=%0b st=%0d pure=%03h",
                     n, ssg_inv, eg_state, eg_pure, e[13], e[12:10], e[9:0]);
         end
         n++;
      end
      // d2r=1 steps +1 only on ticks where eg_cnt[10:0] is zero, across a wrap.
      d1r = 5'd0;
      d2r = 5'd1;
      p   = 10'h008;
      for (int i = 0; i < 4100; i++) begin
         if (tb_cnt[10:0] == 11'd0) p = p + 10'd1;
         exp_q.push_back({1'b0, 3'd3, p});
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({ssg_inv, eg_state, eg_pure} !== e) begin
            errors++;
            $display("FAIL slow_rate tick %0d: got st=%0d pure=%03h expected st=%0d pure=%03h",
                     i, eg_state, eg_pure, e[12:10], e[9:0]);
         end
      end
      checks++;
      if (eg_pure !== 10'h00A) begin
         errors++;
         $display("FAIL slow_rate_total: got %03h expected 00a", eg_pure);
      end
   endtask

   task automatic test_ssg();
      logic [13:0] e;
      int n;
      keyon = 1'b0;
      apply_reset();
      ssg_en   = 1'b1;
      ssg_alt  = 1'b1;
      ssg_hold = 1'b0;
      ar       = 5'd31;
      keyon    = 1'b1;
      exp_q.push_back({1'b0, 3'd2, 10'h000});
`ifdef JT12_EG_SSG_EN
      for (int k = 1; k <= 16; k++) exp_q.push_back({1'b0, 3'd2, 10'(k * 32)});
      exp_q.push_back({1'b1, 3'd1, 10'h200});
      exp_q.push_back({1'b0, 3'd4, 10'h200});
`else
      for (int k = 1; k <= 124; k++) begin
         exp_q.push_back({1'b0, (k * 8 >= 'h3E0) ? 3'd3 : 3'd2, 10'(k * 8)});
      end
`endif
      n = 0;
      while (exp_q.size() > 0) begin
         if (n == 1) begin d1r = 5'd31; sl = 4'hF; end
`ifdef JT12_EG_SSG_EN
         if (n == 18) begin rr = 4'd15; keyon = 1'b0; end
`endif
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({ssg_inv, eg_state, eg_pure} !== e) begin
            errors++;
            $display("FAIL ssg %0d: got inv=%0b st=%0d pure=%03h expected inv=%0b st=%0d pure=%03h",
                     n, ssg_inv, eg_state, eg_pure, e[13], e[12:10], e[9:0]);
         end
         n++;
      end
   endtask

   initial begin
      rst      = 1'b1;
      clk_en   = 1'b0;
      keyon    = 1'b0;
      ar       = 5'd0;
      d1r      = 5'd0;
      d2r      = 5'd0;
      rr       = 4'd0;
      sl       = 4'd0;
      ssg_en   = 1'b0;
      ssg_alt  = 1'b0;
      ssg_hold = 1'b0;
      tb_cnt   = 12'd0;
      #12;
      rst = 1'b0;
      test_reset();
      test_instant_attack();
      test_decay_release();
      test_back_to_back();
      test_slow_rate();
      test_ssg();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
